// File: rtl/uart_frame_deframer.sv
// Sync-hunting frame deframer: captures a fixed-length payload plus an additive
// checksum and releases the payload over valid/ready only when the checksum matches.
module uart_frame_deframer #(
  parameter int unsigned FRAME_LEN      = 64,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned      IDX_W     = $clog2(FRAME_LEN);
  localparam int unsigned      TMR_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_PAYLOAD,
    S_CHECK,
    S_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_CSUM    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  state_e           state_q;
  err_e             err_code_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [TMR_W-1:0] timer_q;
  logic [7:0]       sum_q;
  logic [7:0]       out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             frame_ok_q;
  logic             frame_err_q;
  logic             overrun_q;

  logic [7:0]       mem_q [FRAME_LEN];
  logic             wr_en;
  logic [IDX_W-1:0] rd_next;
  logic             tmo_hit;

  assign wr_en   = (state_q == S_PAYLOAD) && rx_valid;
  assign rd_next = rd_idx_q + IDX_ONE;
  assign tmo_hit = !rx_valid && (timer_q == TMR_LIMIT);

  // NOTE: the payload store has no reset so it can map onto plain RAM; its
  // contents are only read after a full frame has overwritten every entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx_q] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HUNT;
      err_code_q  <= ERR_NONE;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      timer_q     <= '0;
      sum_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: status strobes default low here so each one lasts exactly one cycle.
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      unique case (state_q)
        S_HUNT: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_q  <= S_PAYLOAD;
            wr_idx_q <= '0;
            sum_q    <= '0;
            timer_q  <= '0;
          end
        end

        S_PAYLOAD: begin
          if (rx_valid) begin
            sum_q   <= sum_q + rx_data;
            timer_q <= '0;
            if (wr_idx_q == LAST_IDX) begin
              state_q <= S_CHECK;
            end else begin
              wr_idx_q <= wr_idx_q + IDX_ONE;
            end
          end else if (tmo_hit) begin
            state_q     <= S_HUNT;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
          end else begin
            timer_q <= timer_q + TMR_ONE;
          end
        end

        S_CHECK: begin
          if (rx_valid) begin
            timer_q <= '0;
            if (rx_data == sum_q) begin
              // Prefetch the first byte so out_valid rises on the first DRAIN cycle.
              state_q     <= S_DRAIN;
              frame_ok_q  <= 1'b1;
              rd_idx_q    <= '0;
              out_data_q  <= mem_q[0];
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
            end else begin
              state_q     <= S_HUNT;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CSUM;
            end
          end else if (tmo_hit) begin
            state_q     <= S_HUNT;
            frame_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
          end else begin
            timer_q <= timer_q + TMR_ONE;
          end
        end

        S_DRAIN: begin
          overrun_q <= rx_valid;
          if (out_ready) begin
            if (rd_idx_q == LAST_IDX) begin
              state_q     <= S_HUNT;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              rd_idx_q   <= rd_next;
              out_data_q <= mem_q[rd_next];
              out_last_q <= (rd_next == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_HUNT);

endmodule

// File: doc/uart_frame_deframer.md
Name: uart_frame_deframer

Overview:
- Upstream stage of the UART edge-detection core; sits between the UART byte receiver and the image-processing FSM.
- Hunts for a sync byte and captures a fixed-length pixel payload followed by an 8-bit additive checksum.
- Releases the payload downstream over a valid/ready byte stream only after the checksum matches, so corrupt or truncated frames never reach the convolution buffer.

Parameters:
- FRAME_LEN, 64, payload bytes per frame (8x8 image); legal range 2..256.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 50000, max clk cycles between bytes inside a frame (about 11 byte times at 115200 baud, 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  single-cycle strobe; rx_data is valid when high.
- out_data  out  8  payload byte to downstream.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte when out_valid and out_ready are both high.
- out_last  out  1  high with the final payload byte.
- frame_ok  out  1  one-cycle pulse when a frame passes the checksum.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- err_code  out  2  cause of the last error, held until the next error: 01 = checksum, 10 = timeout.
- overrun  out  1  one-cycle pulse when a byte is dropped during DRAIN.
- busy  out  1  high whenever state is not HUNT.

Behaviour:
- Reset (async, any time): state=HUNT; out_valid, out_last, frame_ok, frame_err and overrun =0; out_data=0; err_code=00; all counters and sum =0. Buffer contents are don't-care.
- States: HUNT, PAYLOAD, CHECK, DRAIN.
- HUNT:
  - rx_valid with rx_data==SYNC_BYTE: go to PAYLOAD; wr_idx=0, sum=0, timer=0.
  - Any other byte is silently ignored; no error, no pulse.
- PAYLOAD:
  - On each rx_valid: buf[wr_idx]<=rx_data; sum<=sum+rx_data (mod 256); timer=0.
  - When wr_idx==FRAME_LEN-1, go to CHECK; otherwise wr_idx++.
  - A SYNC_BYTE value here is treated as payload, not as a restart.
- CHECK:
  - On rx_valid, compare rx_data to sum.
  - Match: go to DRAIN; frame_ok pulses the following cycle.
  - Mismatch: go to HUNT; frame_err pulses the following cycle; err_code<=01.
- Timeout (PAYLOAD and CHECK only):
  - timer increments every cycle without rx_valid.
  - When timer reaches TIMEOUT_CYCLES-1 without rx_valid: go to HUNT; frame_err pulses; err_code<=10.
  - rx_valid in the same cycle as the limit wins; the byte is processed and the timer clears.
- DRAIN:
  - rd_idx starts at 0. out_valid=1 from the first DRAIN cycle, i.e. the cycle after the checksum byte's rx_valid.
  - out_data=buf[rd_idx], registered, stable while out_valid && !out_ready.
  - out_last=1 when rd_idx==FRAME_LEN-1.
  - On a handshake, rd_idx++. The next byte may be presented the following cycle, so one byte per cycle is allowed.
  - On the handshake of the last byte: out_valid=0 next cycle; go to HUNT.
  - out_valid never drops before its handshake.
- rx_valid during DRAIN: byte dropped; overrun pulses the next cycle. Sync detection does not run until HUNT.
- Width rules:
  - wr_idx and rd_idx: $clog2(FRAME_LEN) bits.
  - timer: $clog2(TIMEOUT_CYCLES) bits, saturates at the limit.
  - sum: 8 bits, wraps.
- Buffer: FRAME_LEN x 8 register array or inferred RAM with a registered read. Read latency must be hidden so the out_valid timing above holds.
- The three status pulses are mutually exclusive per cycle by construction.

Test Plan:
- FRAME_LEN=4, TIMEOUT=100. Send A5 01 02 03 04 0A with out_ready=1:
  - frame_ok pulses once.
  - out_data 01,02,03,04 on consecutive cycles; out_last only with 04.
  - busy returns to 0 after the last handshake.
- Same frame with checksum 0B:
  - frame_err pulses, err_code=01, out_valid never asserts, state returns to HUNT.
  - A following good frame is delivered intact.
- Send A5 01 02, then idle 100 cycles:
  - frame_err pulses at the timeout, err_code=10.
  - Garbage bytes 00 FF before the next A5 are ignored, and that next frame is delivered.
- Good frame with out_ready toggled 1,0,0,1,0,1:
  - Each byte is held stable while stalled; no byte is lost or duplicated.
  - 4 handshakes total.
- During a stalled DRAIN, inject rx_valid bytes 55 and A5:
  - overrun pulses twice; the drained data is unchanged.
  - After the drain completes, the next A5 frame is accepted normally.
- Assert rst mid-PAYLOAD and again mid-DRAIN:
  - All outputs go to 0 immediately (asynchronously); err_code=00.
  - After rst deasserts, a full frame is received correctly.
